// File: rtl/hps_gpio_bank.sv
// hps_gpio_bank: WIDTH-channel GPIO bank with input sync, debounce, edge interrupts and a CSR port
module hps_gpio_bank #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [2:0]       CSR_ADDR,
    input  logic             CSR_WR,
    input  logic [WIDTH-1:0] CSR_WDATA,
    input  logic             CSR_RD,
    output logic [WIDTH-1:0] CSR_RDATA,
    output logic             CSR_RVALID,
    input  logic [WIDTH-1:0] PIN_I,
    output logic [WIDTH-1:0] PIN_O,
    output logic [WIDTH-1:0] PIN_OE,
    output logic             IRQ
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam int IW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, irq_en_q, irq_en_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d, rdata_q, rdata_d;
    logic [WIDTH-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    init_q, init_d;
    logic             irq_q, irq_d, rvalid_q, rvalid_d;
    logic [7:0]       we;
    logic [WIDTH-1:0] sync, set, rsel;

    // Shift pad inputs through the synchroniser chain
    always_comb begin
        sync_d[0] = PIN_I;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    end

    // INIT waits for the synchroniser to fill and seeds deb without an edge; RUN debounces each channel
    always_comb begin
        sync       = sync_q[SYNC_STAGES-1];
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        init_d     = init_q;
        if (state_q == ST_INIT) begin
            if (init_q == INIT_LAST) begin
                deb_d      = sync;
                deb_prev_d = sync;
                state_d    = ST_RUN;
            end else begin
                init_d = init_q + 1'b1;
            end
        end else if (DEBOUNCE_CYCLES == 0) begin
            deb_d = sync;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= CNT_MAX) begin
                    deb_d[i] = sync[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Register read mux, values as of the read cycle
    always_comb begin
        case (CSR_ADDR)
            3'd0:    rsel = out_q;
            3'd1:    rsel = dir_q;
            3'd2:    rsel = deb_q;
            3'd3:    rsel = irq_en_q;
            3'd4:    rsel = rise_en_q;
            3'd5:    rsel = fall_en_q;
            3'd6:    rsel = status_q;
            default: rsel = '0;
        endcase
    end

    // CSR writes, W1C status with set priority, registered IRQ and read return
    always_comb begin
        we        = CSR_WR ? (8'd1 << CSR_ADDR) : 8'd0;
        set       = (state_q == ST_RUN) ? ((deb_q & ~deb_prev_q & rise_en_q) | (~deb_q & deb_prev_q & fall_en_q)) : '0;
        out_d     = we[0] ? CSR_WDATA : out_q;
        dir_d     = we[1] ? CSR_WDATA : dir_q;
        irq_en_d  = we[3] ? CSR_WDATA : irq_en_q;
        rise_en_d = we[4] ? CSR_WDATA : rise_en_q;
        fall_en_d = we[5] ? CSR_WDATA : fall_en_q;
        status_d  = (status_q & ~(we[6] ? CSR_WDATA : '0)) | set;
        irq_d     = |(status_q & irq_en_q);
        rdata_d   = CSR_RD ? rsel : rdata_q;
        rvalid_d  = CSR_RD;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q      <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            sync_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
            state_q    <= ST_INIT;
            init_q     <= '0;
            irq_q      <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            init_q     <= init_d;
            irq_q      <= irq_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign PIN_O      = out_q;
    assign PIN_OE     = dir_q;
    assign IRQ        = irq_q;
    assign CSR_RDATA  = rdata_q;
    assign CSR_RVALID = rvalid_q;
endmodule
